// File: rtl/lsu_mmio_param.sv
`default_nettype none
// ============================================================================
// Module      : lsu_mmio_param
// Description : MEM-stage load/store unit. It holds a byte-addressable data
//               RAM plus memory-mapped LED, 7-segment, LCD and switch
//               registers. Requests use a valid/ready handshake, and every
//               accepted request gets exactly one registered response one
//               cycle later. Faults cover illegal size, misalignment and
//               unmapped addresses. LCD writes stall the port for LCD_HOLD
//               cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_mmio_param #(
  parameter int DMEM_WORDS = 2048,
  parameter int N_HEX      = 8,
  parameter int LCD_HOLD   = 4,
  parameter int SW_SYNC    = 2
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_req,
  output logic                 o_ready,
  input  logic                 i_wren,
  input  logic [31:0]          i_addr,
  input  logic [31:0]          i_wdata,
  input  logic [1:0]           i_size,
  input  logic                 i_unsigned,
  output logic                 o_rvalid,
  output logic [31:0]          o_rdata,
  output logic                 o_err,
  output logic [31:0]          o_io_ledr,
  output logic [31:0]          o_io_ledg,
  output logic [7*N_HEX-1:0]   o_io_hex,
  output logic [31:0]          o_io_lcd,
  input  logic [31:0]          i_io_sw
);

  localparam int c_aw   = $clog2(DMEM_WORDS);
  localparam int c_cw   = (LCD_HOLD > 1) ? $clog2(LCD_HOLD) : 1;
  localparam logic [c_cw-1:0] c_hold_load = c_cw'((LCD_HOLD > 0) ? LCD_HOLD - 1 : 0);
  localparam bit c_stall = (LCD_HOLD > 0);

  typedef enum logic [0:0] {
    LCD_IDLE = 1'b0,
    LCD_BUSY = 1'b1
  } lcd_state_t;

  // --------------------------------------------------------------------------
  // Address decode and fault detection
  // --------------------------------------------------------------------------
  logic [19:0] w_page;
  logic        w_is_ram, w_is_ledr, w_is_ledg, w_is_hex, w_is_lcd, w_is_sw;
  logic        w_hex_hi, w_mapped, w_misal, w_fault;
  logic        w_acc, w_wr_ok;
  logic [c_aw-1:0] w_widx;

  assign w_page    = i_addr[31:12];
  assign w_is_ram  = (i_addr[31:c_aw+2] == '0);
  assign w_is_ledr = (w_page == 20'h10000);
  assign w_is_ledg = (w_page == 20'h10001);
  assign w_is_hex  = (w_page == 20'h10002) || (w_page == 20'h10003);
  assign w_is_lcd  = (w_page == 20'h10004);
  assign w_is_sw   = (w_page == 20'h10010);
  // Page 0x1000_3xxx carries digits 4..7; bit 12 tells the two HEX pages apart.
  assign w_hex_hi  = i_addr[12];
  assign w_mapped  = w_is_ram | w_is_ledr | w_is_ledg | w_is_hex | w_is_lcd | w_is_sw;
  assign w_misal   = ((i_size == 2'b10) && (i_addr[1:0] != 2'b00)) ||
                     ((i_size == 2'b01) && i_addr[0]);
  assign w_fault   = (i_size == 2'b11) || w_misal || !w_mapped;
  assign w_acc     = i_req && o_ready;
  assign w_wr_ok   = w_acc && i_wren && !w_fault;
  assign w_widx    = i_addr[c_aw+1:2];

  // --------------------------------------------------------------------------
  // Store byte enables and lane-replicated write data
  // --------------------------------------------------------------------------
  logic [3:0]  w_be;
  logic [31:0] w_wlanes;

  // Right-justified store data is replicated so each enabled lane sees its byte.
  always_comb begin
    w_be     = 4'b0000;
    w_wlanes = i_wdata;
    case (i_size)
      2'b00: begin
        w_be     = 4'b0001 << i_addr[1:0];
        w_wlanes = {4{i_wdata[7:0]}};
      end
      2'b01: begin
        w_be     = i_addr[1] ? 4'b1100 : 4'b0011;
        w_wlanes = {2{i_wdata[15:0]}};
      end
      2'b10:   w_be = 4'b1111;
      default: w_be = 4'b0000;
    endcase
  end

  // --------------------------------------------------------------------------
  // Data RAM (not reset)
  // --------------------------------------------------------------------------
  logic [31:0] r_mem [DMEM_WORDS];
  logic [31:0] r_ram_q;

  // Byte-enabled write at the accept edge; synchronous read captured on accept.
  always_ff @(posedge i_clk) begin
    if (w_wr_ok && w_is_ram) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_widx][8*b +: 8] <= w_wlanes[8*b +: 8];
      end
    end
    if (w_acc) r_ram_q <= r_mem[w_widx];
  end

  // --------------------------------------------------------------------------
  // LED and LCD output registers
  // --------------------------------------------------------------------------
  logic [31:0] r_ledr, r_ledg, r_lcd;

  // Lane-merged writes into the 32-bit output registers.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_ledr <= '0;
      r_ledg <= '0;
      r_lcd  <= '0;
    end else if (w_wr_ok) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b] && w_is_ledr) r_ledr[8*b +: 8] <= w_wlanes[8*b +: 8];
        if (w_be[b] && w_is_ledg) r_ledg[8*b +: 8] <= w_wlanes[8*b +: 8];
        if (w_be[b] && w_is_lcd)  r_lcd[8*b +: 8]  <= w_wlanes[8*b +: 8];
      end
    end
  end

  assign o_io_ledr = r_ledr;
  assign o_io_ledg = r_ledg;
  assign o_io_lcd  = r_lcd;

  // --------------------------------------------------------------------------
  // 7-segment digits; unimplemented digit positions read as zero
  // --------------------------------------------------------------------------
  logic [55:0] w_hex_all;

  for (genvar k = 0; k < N_HEX; k++) begin : g_hex
    localparam logic c_page = (k >= 4);
    logic [6:0] r_digit;

    // Digit k owns lane k%4 of its page; bit 7 of the lane is dropped.
    always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
        r_digit <= '0;
      end else if (w_wr_ok && w_is_hex && (w_hex_hi == c_page) && w_be[k % 4]) begin
        r_digit <= w_wlanes[8*(k % 4) +: 7];
      end
    end

    assign w_hex_all[7*k +: 7] = r_digit;
  end

  for (genvar k = N_HEX; k < 8; k++) begin : g_hex_pad
    assign w_hex_all[7*k +: 7] = 7'h00;
  end

  assign o_io_hex = w_hex_all[7*N_HEX-1:0];

  // --------------------------------------------------------------------------
  // Switch synchroniser
  // --------------------------------------------------------------------------
  logic [31:0] r_sw_sync [SW_SYNC];

  // Plain shift chain; the last stage is the only value software sees.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int s = 0; s < SW_SYNC; s++) r_sw_sync[s] <= '0;
    end else begin
      r_sw_sync[0] <= i_io_sw;
      for (int s = 1; s < SW_SYNC; s++) r_sw_sync[s] <= r_sw_sync[s-1];
    end
  end

  // --------------------------------------------------------------------------
  // IO read mux, sampled at the accept edge
  // --------------------------------------------------------------------------
  logic [31:0] w_hex_rd, w_io_rd;

  // HEX reads pack {1'b0, digit} into each lane of the addressed page.
  always_comb begin
    w_hex_rd = '0;
    for (int j = 0; j < 4; j++) begin
      w_hex_rd[8*j +: 8] = {1'b0, (w_hex_hi ? w_hex_all[7*(j+4) +: 7] : w_hex_all[7*j +: 7])};
    end
  end

  // Selects the full IO word for the addressed register.
  always_comb begin
    w_io_rd = '0;
    if (w_is_ledr)      w_io_rd = r_ledr;
    else if (w_is_ledg) w_io_rd = r_ledg;
    else if (w_is_hex)  w_io_rd = w_hex_rd;
    else if (w_is_lcd)  w_io_rd = r_lcd;
    else if (w_is_sw)   w_io_rd = r_sw_sync[SW_SYNC-1];
  end

  // --------------------------------------------------------------------------
  // Response pipeline register
  // --------------------------------------------------------------------------
  logic        r_rvalid, r_err, r_load, r_from_ram, r_raw, r_uns;
  logic [1:0]  r_size, r_off;
  logic [31:0] r_io_q;

  // Captures everything needed to shape the load result on the next cycle.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_rvalid   <= 1'b0;
      r_err      <= 1'b0;
      r_load     <= 1'b0;
      r_from_ram <= 1'b0;
      r_raw      <= 1'b0;
      r_uns      <= 1'b0;
      r_size     <= 2'b00;
      r_off      <= 2'b00;
      r_io_q     <= '0;
    end else begin
      r_rvalid <= w_acc;
      r_err    <= w_acc && w_fault;
      r_load   <= w_acc && !i_wren && !w_fault;
      if (w_acc) begin
        r_from_ram <= w_is_ram;
        r_raw      <= w_is_sw;
        r_uns      <= i_unsigned;
        r_size     <= i_size;
        r_off      <= i_addr[1:0];
        r_io_q     <= w_io_rd;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Lane extraction and sign/zero extension on the response cycle
  // --------------------------------------------------------------------------
  logic [31:0] w_rword, w_shift, w_load_val;

  assign w_rword = r_from_ram ? r_ram_q : r_io_q;
  assign w_shift = w_rword >> {r_off, 3'b000};

  // Switch reads bypass lane selection and return the whole synchronised word.
  always_comb begin
    w_load_val = w_rword;
    case (r_size)
      2'b00:   w_load_val = r_uns ? {24'h0, w_shift[7:0]}  : {{24{w_shift[7]}}, w_shift[7:0]};
      2'b01:   w_load_val = r_uns ? {16'h0, w_shift[15:0]} : {{16{w_shift[15]}}, w_shift[15:0]};
      default: w_load_val = w_rword;
    endcase
    if (r_raw) w_load_val = r_io_q;
  end

  assign o_rvalid = r_rvalid;
  assign o_err    = r_err;
  assign o_rdata  = r_load ? w_load_val : 32'h0;

  // --------------------------------------------------------------------------
  // LCD pacing FSM
  // --------------------------------------------------------------------------
  lcd_state_t      r_state, w_state_nxt;
  logic [c_cw-1:0] r_cnt, w_cnt_nxt;
  logic            w_lcd_start;

  assign w_lcd_start = c_stall && w_wr_ok && w_is_lcd;
  assign o_ready     = (r_state == LCD_IDLE);

  // State and hold counter registers.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= LCD_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Counter reaches zero on the last busy cycle, then returns to idle.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      LCD_IDLE: begin
        if (w_lcd_start) begin
          w_state_nxt = LCD_BUSY;
          w_cnt_nxt   = c_hold_load;
        end
      end
      LCD_BUSY: begin
        if (r_cnt == '0) w_state_nxt = LCD_IDLE;
        else             w_cnt_nxt   = r_cnt - c_cw'(1);
      end
      default: w_state_nxt = LCD_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_lsu_mmio_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_lsu_mmio_param
// Description : Scoreboard bench for lsu_mmio_param. A byte-level memory-map
//               model predicts each response and pushes it on accept; a
//               separate monitor pops and compares on every o_rvalid.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu_mmio_param;

  localparam int DMEM_WORDS = 256;
  localparam int N_HEX      = 6;
  localparam int LCD_HOLD   = 4;
  localparam int SW_SYNC    = 2;
  localparam int RAM_BYTES  = DMEM_WORDS * 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req, ready, wren, uns, rvalid, err;
  logic [31:0]       addr, wdata, rdata, ledr, ledg, lcd, sw;
  logic [1:0]        size;
  logic [7*N_HEX-1:0] hex;

  lsu_mmio_param #(
    .DMEM_WORDS(DMEM_WORDS), .N_HEX(N_HEX), .LCD_HOLD(LCD_HOLD), .SW_SYNC(SW_SYNC)
  ) dut (
    .i_clk(clk), .i_reset(rst_n), .i_req(req), .o_ready(ready), .i_wren(wren),
    .i_addr(addr), .i_wdata(wdata), .i_size(size), .i_unsigned(uns),
    .o_rvalid(rvalid), .o_rdata(rdata), .o_err(err),
    .o_io_ledr(ledr), .o_io_ledg(ledg), .o_io_hex(hex), .o_io_lcd(lcd), .i_io_sw(sw)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0]  m_ram [RAM_BYTES];
  logic [31:0] m_ledr, m_ledg, m_lcd;
  logic [6:0]  m_hex [8];
  logic [31:0] sw_cur, sw_prev;
  int          sw_chg, lcd_free;

  function automatic int region(input logic [31:0] a);
    if (a < RAM_BYTES) return 0;
    case (a[31:12])
      20'h10000:           return 1;
      20'h10001:           return 2;
      20'h10002, 20'h10003: return 3;
      20'h10004:           return 4;
      20'h10010:           return 5;
      default:             return -1;
    endcase
  endfunction

  function automatic logic [31:0] sw_visible();
    return (cyc - sw_chg >= SW_SYNC) ? sw_cur : sw_prev;
  endfunction

  function automatic int hex_digit(input logic [31:0] a);
    return (a[12] ? 4 : 0) + int'(a[1:0]);
  endfunction

  task automatic wr_byte(input logic [31:0] a, input logic [7:0] v);
    case (region(a))
      0: m_ram[a[9:0]] = v;
      1: m_ledr[8*a[1:0] +: 8] = v;
      2: m_ledg[8*a[1:0] +: 8] = v;
      3: if (hex_digit(a) < N_HEX) m_hex[hex_digit(a)] = v[6:0];
      4: m_lcd[8*a[1:0] +: 8] = v;
      default: ;
    endcase
  endtask

  function automatic logic [7:0] rd_byte(input logic [31:0] a);
    case (region(a))
      0: return m_ram[a[9:0]];
      1: return m_ledr[8*a[1:0] +: 8];
      2: return m_ledg[8*a[1:0] +: 8];
      3: return (hex_digit(a) < N_HEX) ? {1'b0, m_hex[hex_digit(a)]} : 8'h00;
      4: return m_lcd[8*a[1:0] +: 8];
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                              input logic [1:0] sz, input logic u,
                              output logic [31:0] data, output logic fault);
    int n;
    int r;
    logic [31:0] v;
    logic [31:0] ones;
    n     = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    r     = region(a);
    fault = (sz == 2'd3) || (sz == 2'd2 && a[1:0] != 2'b00) || (sz == 2'd1 && a[0]) || (r < 0);
    data  = 32'h0;
    if (fault) return;
    if (w) begin
      for (int i = 0; i < n; i++) wr_byte(a + 32'(i), d[8*i +: 8]);
      if (r == 4 && LCD_HOLD > 0) lcd_free = cyc + 1 + LCD_HOLD;
    end else if (r == 5) begin
      data = sw_visible();
    end else begin
      v = 32'h0;
      for (int i = 0; i < n; i++) v[8*i +: 8] = rd_byte(a + 32'(i));
      ones = '1;
      if (n < 4 && !u && v[8*n-1]) v = v | (ones << (8*n));
      data = v;
    end
  endtask

  // Issue one request at a negedge, holding it until the DUT accepts.
  task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [1:0] sz, input logic u, output int acc);
    int   waited;
    exp_t e;
    waited = 0;
    acc    = -1;
    req = 1'b1; wren = w; addr = a; wdata = d; size = sz; uns = u;
    forever begin
      chk("ready", 64'(ready), 64'(cyc >= lcd_free));
      if (ready) break;
      waited++;
      if (waited > 20) begin
        checks++; errors++;
        $display("FAIL ready_timeout: got ready=0 for %0d cycles expected ready=1", waited);
        req = 1'b0;
        return;
      end
      @(negedge clk);
    end
    acc = cyc + 1;
    model_access(w, a, d, sz, u, e.data, e.err);
    e.cyc = acc;
    sb.push_back(e);
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic chk_io();
    logic [7*N_HEX-1:0] hx;
    for (int k = 0; k < N_HEX; k++) hx[7*k +: 7] = m_hex[k];
    chk("ledr", 64'(ledr), 64'(m_ledr));
    chk("ledg", 64'(ledg), 64'(m_ledg));
    chk("lcd",  64'(lcd),  64'(m_lcd));
    chk("hex",  64'(hex),  64'(hx));
  endtask

  task automatic set_sw(input logic [31:0] v);
    sw_prev = sw_visible();
    sw_cur  = v;
    sw      = v;
    sw_chg  = cyc;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin : mon
    exp_t e;
    if (sb.size() > 0 && sb[0].cyc < cyc) begin
      checks++; errors++;
      $display("FAIL no_response: got no rvalid expected one at cycle %0d", sb[0].cyc);
      void'(sb.pop_front());
    end
    if (rvalid) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL spurious_rvalid: got rvalid=1 expected 0 at cycle %0d", cyc);
      end else begin
        e = sb.pop_front();
        chk("rdata",   64'(rdata), 64'(e.data));
        chk("err",     64'(err),   64'(e.err));
        chk("latency", 64'(cyc),   64'(e.cyc));
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    int a0, a1, r;
    logic [31:0] a;
    logic [1:0]  sz;
    logic [31:0] bad [5];
    bad[0] = 32'h2000_0000; bad[1] = 32'(RAM_BYTES); bad[2] = 32'h1000_5000;
    bad[3] = 32'h1001_1000; bad[4] = 32'hFFFF_FFFC;

    rst_n = 1'b0; req = 1'b0; wren = 1'b0; addr = '0; wdata = '0; size = '0; uns = 1'b0;
    sw = '0; sw_cur = '0; sw_prev = '0; sw_chg = 0; lcd_free = 0;
    m_ledr = '0; m_ledg = '0; m_lcd = '0;
    for (int k = 0; k < 8; k++) m_hex[k] = '0;

    repeat (3) @(negedge clk);
    chk("rst_ready",  64'(ready),  64'(1));
    chk("rst_rvalid", 64'(rvalid), 64'(0));
    chk("rst_err",    64'(err),    64'(0));
    chk("rst_rdata",  64'(rdata),  64'(0));
    chk_io();
    rst_n = 1'b1;
    sw_chg = cyc;
    @(negedge clk);

    // Known RAM contents everywhere.
    for (int w = 0; w < DMEM_WORDS; w++) do_req(1'b1, 32'(w * 4), $urandom, 2'd2, 1'b0, a0);

    // Sub-word loads from a stored word.
    do_req(1'b1, 32'h100, 32'h1234_5678, 2'd2, 1'b0, a0);
    do_req(1'b0, 32'h101, 32'h0, 2'd0, 1'b0, a0);
    do_req(1'b0, 32'h103, 32'h0, 2'd0, 1'b1, a0);
    do_req(1'b0, 32'h102, 32'h0, 2'd1, 1'b0, a0);
    // Store then immediate load of the same byte, signed and unsigned.
    do_req(1'b1, 32'h203, 32'hFF, 2'd0, 1'b0, a0);
    do_req(1'b0, 32'h203, 32'h0, 2'd0, 1'b0, a0);
    do_req(1'b0, 32'h203, 32'h0, 2'd0, 1'b1, a0);
    // Faulting accesses, then readback.
    do_req(1'b0, 32'h102, 32'h0, 2'd2, 1'b0, a0);
    do_req(1'b1, 32'h101, 32'hBEEF, 2'd1, 1'b0, a0);
    do_req(1'b1, 32'h2000_0000, 32'hCAFE, 2'd2, 1'b0, a0);
    do_req(1'b0, 32'h2000_0000, 32'h0, 2'd2, 1'b0, a0);
    do_req(1'b1, 32'h100, 32'h55, 2'd3, 1'b0, a0);
    do_req(1'b1, 32'(RAM_BYTES), 32'h1, 2'd2, 1'b0, a0);
    do_req(1'b0, 32'h100, 32'h0, 2'd2, 1'b0, a0);
    // LEDs.
    do_req(1'b1, 32'h1000_0000, 32'hA1B2_C3D4, 2'd2, 1'b0, a0);
    do_req(1'b1, 32'h1000_1002, 32'h9876, 2'd1, 1'b0, a0);
    do_req(1'b0, 32'h1000_1002, 32'h0, 2'd1, 1'b0, a0);
    chk_io();
    // LCD store stalls the port; a held request follows LCD_HOLD+1 cycles later.
    do_req(1'b1, 32'h1000_4000, 32'hA5, 2'd2, 1'b0, a0);
    do_req(1'b0, 32'h100, 32'h0, 2'd2, 1'b0, a1);
    chk("lcd_gap", 64'(a1 - a0), 64'(LCD_HOLD + 1));
    chk_io();
    // HEX: digit 5 exists, digit 6 does not.
    do_req(1'b1, 32'h1000_3001, 32'h3F, 2'd0, 1'b0, a0);
    do_req(1'b1, 32'h1000_3002, 32'h7E, 2'd0, 1'b0, a0);
    do_req(1'b1, 32'h1000_2000, 32'h8180_7F01, 2'd2, 1'b0, a0);
    do_req(1'b0, 32'h1000_3000, 32'h0, 2'd2, 1'b0, a0);
    do_req(1'b0, 32'h1000_2000, 32'h0, 2'd2, 1'b0, a0);
    chk_io();
    // Switches become visible only after the synchroniser delay.
    set_sw(32'hDEAD_BEEF);
    do_req(1'b0, 32'h1001_0000, 32'h0, 2'd2, 1'b0, a0);
    do_req(1'b0, 32'h1001_0000, 32'h0, 2'd2, 1'b0, a0);
    do_req(1'b0, 32'h1001_0000, 32'h0, 2'd2, 1'b0, a0);
    do_req(1'b0, 32'h1001_0001, 32'h0, 2'd0, 1'b0, a0);
    do_req(1'b1, 32'h1001_0000, 32'h1111, 2'd2, 1'b0, a0);

    // Randomised traffic over the whole map.
    for (int it = 0; it < 400; it++) begin
      if ($urandom_range(0, 15) == 0 && (cyc - sw_chg >= SW_SYNC)) set_sw($urandom);
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2, 3: a = 32'($urandom_range(0, RAM_BYTES - 1));
        4: a = 32'h1000_0000 | 32'($urandom_range(0, 32'hFFF));
        5: a = 32'h1000_1000 | 32'($urandom_range(0, 32'hFFF));
        6: a = 32'h1000_2000 | 32'($urandom_range(0, 32'h1FFF));
        7: a = 32'h1000_4000 | 32'($urandom_range(0, 32'hFFF));
        8: a = 32'h1001_0000 | 32'($urandom_range(0, 32'hFFF));
        default: a = bad[$urandom_range(0, 4)];
      endcase
      sz = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd1) a[0] = 1'b0;
        if (sz == 2'd2) a[1:0] = 2'b00;
      end
      do_req(1'($urandom_range(0, 1)), a, $urandom, sz, 1'($urandom_range(0, 1)), a0);
      if (it % 50 == 49) chk_io();
    end

    // Reset while the LCD stall is in progress.
    do_req(1'b1, 32'h1000_4000, 32'h77, 2'd2, 1'b0, a0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    m_ledr = '0; m_ledg = '0; m_lcd = '0;
    for (int k = 0; k < 8; k++) m_hex[k] = '0;
    lcd_free = 0;
    chk("midbusy_ready",  64'(ready),  64'(1));
    chk("midbusy_rvalid", 64'(rvalid), 64'(0));
    chk("midbusy_err",    64'(err),    64'(0));
    chk("midbusy_rdata",  64'(rdata),  64'(0));
    chk_io();
    @(negedge clk);
    rst_n   = 1'b1;
    sw_prev = '0;
    sw_chg  = cyc;
    do_req(1'b0, 32'h1001_0000, 32'h0, 2'd2, 1'b0, a0);
    do_req(1'b0, 32'h1001_0000, 32'h0, 2'd2, 1'b0, a0);
    do_req(1'b0, 32'h1001_0000, 32'h0, 2'd2, 1'b0, a0);
    do_req(1'b0, 32'h100, 32'h0, 2'd2, 1'b0, a0);
    do_req(1'b0, 32'h1000_4000, 32'h0, 2'd2, 1'b0, a0);

    repeat (3) @(negedge clk);
    chk("sb_empty", 64'(sb.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
